synth_param_bank: RTL and testbench

Parameter register bank for the synthesizer front end. It holds NUM_PARAMS independent, saturating parameter values such as octave, amplitude, attack, decay, sustain and release. Each value is adjusted by keyboard-driven increment/decrement levels, with optional hold-to-repeat, or loaded directly. It sits between the PS/2 decoder and the ALU/voice controller, and also feeds the HEX display path.

---
 rtl/synth_param_bank.sv | 195 +++++++++++++++++++
 tb/tb_synth_param_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/synth_param_bank.sv
// synth_param_bank -- saturating parameter register bank for the synth front end.
//
// Holds NUM_PARAMS values of WIDTH bits. The selected value is stepped up or
// down by STEP on rising edges of inc/dec (saturating at 0 and 2^WIDTH-1),
// or written directly with load/load_value. Load takes priority over a step.
//
// Optional build macro: PARAM_AUTOREPEAT_EN
//   defined   -> a held inc/dec repeats after REPEAT_DELAY cycles, then every
//                REPEAT_RATE cycles (IDLE/HOLD/REPEAT FSM with counter).
//   undefined -> edge steps only; a held key produces a single step.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-low reset
//   sel         index of the parameter to adjust
//   inc, dec    increment / decrement request levels
//   load        single-cycle direct-write strobe
//   load_value  value written on load
//   params_out  all parameters packed, param i at [i*WIDTH +: WIDTH]
//   sel_value   registered copy of param[sel] (0 when sel is out of range)
//   changed     one-cycle pulse: a parameter value changed
//   sat         one-cycle pulse: a requested step was clamped
module synth_param_bank #(
   parameter int NUM_PARAMS = 6,
   parameter int WIDTH = 8,
   parameter int STEP = 8,
   parameter logic [NUM_PARAMS*WIDTH-1:0] DEFAULTS = '1,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE = 5000000,
   localparam int SEL_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [SEL_W-1:0]            sel,
   input  logic                        inc,
   input  logic                        dec,
   input  logic                        load,
   input  logic [WIDTH-1:0]            load_value,
   output logic [NUM_PARAMS*WIDTH-1:0] params_out,
   output logic [WIDTH-1:0]            sel_value,
   output logic                        changed,
   output logic                        sat
);

   if (STEP < 1 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_param_check
      $error("synth_param_bank: STEP must be >= 1, REPEAT_DELAY/REPEAT_RATE >= 2");
   end

   localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] MAXV   = '1;

   logic [WIDTH-1:0] p_q [NUM_PARAMS];
   logic             inc_q, dec_q;
   logic [WIDTH-1:0] cur, def_sel, nxt;
   logic [WIDTH:0]   sum;
   logic             sel_valid, both, req_ok, inc_edge, dec_edge;
   logic             rep_up, rep_dn, step_up, step_dn;
   logic             wr, chg_n, sat_n;

   assign sel_valid = ({1'b0, sel} < (SEL_W+1)'(NUM_PARAMS));
   assign both      = inc & dec;
   assign req_ok    = sel_valid & ~load & ~both;
   assign inc_edge  = inc & ~inc_q;
   assign dec_edge  = dec & ~dec_q;
   assign step_up   = req_ok & (inc_edge | rep_up);
   assign step_dn   = req_ok & (dec_edge | rep_dn);

   // Mux out the selected value and its default; out-of-range sel reads 0.
   always_comb begin
      cur     = '0;
      def_sel = '0;
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
         if (sel == SEL_W'(i)) begin
            cur     = p_q[i];
            def_sel = DEFAULTS[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      params_out = '0;
      for (int unsigned i = 0; i < NUM_PARAMS; i++)
         params_out[i*WIDTH +: WIDTH] = p_q[i];
   end

   // Next value for param[sel]; the carry out of the WIDTH+1 bit sum marks clamping.
   always_comb begin
      sum   = {1'b0, cur} + STEP_X;
      nxt   = cur;
      wr    = 1'b0;
      chg_n = 1'b0;
      sat_n = 1'b0;
      if (sel_valid && load) begin
         nxt   = load_value;
         wr    = 1'b1;
         chg_n = (load_value != cur);
      end else if (step_up) begin
         nxt   = sum[WIDTH] ? MAXV : sum[WIDTH-1:0];
         sat_n = sum[WIDTH];
         wr    = 1'b1;
         chg_n = (nxt != cur);
      end else if (step_dn) begin
         nxt   = (cur < STEP_N) ? '0 : cur - STEP_N;
         sat_n = (cur < STEP_N);
         wr    = 1'b1;
         chg_n = (nxt != cur);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_PARAMS; i++)
            p_q[i] <= DEFAULTS[i*WIDTH +: WIDTH];
         // Held keys must be released and re-pressed after reset.
         inc_q     <= 1'b1;
         dec_q     <= 1'b1;
         changed   <= 1'b0;
         sat       <= 1'b0;
         sel_value <= def_sel;
      end else begin
         inc_q     <= inc;
         dec_q     <= dec;
         changed   <= chg_n;
         sat       <= sat_n;
         sel_value <= cur;
         for (int unsigned i = 0; i < NUM_PARAMS; i++)
            if (wr && sel == SEL_W'(i))
               p_q[i] <= nxt;
      end
   end

`ifdef PARAM_AUTOREPEAT_EN
   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             dir_up;
   logic [SEL_W-1:0] sel_q;
   logic             abort, rep_fire, edge_fire;

   assign abort = ~sel_valid | both | load | (sel != sel_q) |
                  (dir_up ? ~inc : ~dec);
   assign rep_fire = ~abort &
                     (((state == HOLD)   && (cnt == CNT_W'(REPEAT_DELAY-1))) ||
                      ((state == REPEAT) && (cnt == CNT_W'(REPEAT_RATE-1))));
   assign rep_up    = rep_fire & dir_up;
   assign rep_dn    = rep_fire & ~dir_up;
   assign edge_fire = req_ok & (inc_edge | dec_edge);

   // A fresh edge wins over abort: releasing one key while pressing the other
   // restarts the hold in the new direction.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         dir_up <= 1'b1;
         sel_q  <= sel;
      end else begin
         sel_q <= sel;
         if (edge_fire) begin
            state  <= HOLD;
            cnt    <= '0;
            dir_up <= inc_edge;
         end else if (state != IDLE && abort) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               HOLD:
                  if (cnt == CNT_W'(REPEAT_DELAY-1)) begin
                     cnt   <= '0;
                     state <= REPEAT;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               REPEAT:
                  if (cnt == CNT_W'(REPEAT_RATE-1))
                     cnt <= '0;
                  else
                     cnt <= cnt + 1'b1;
               default: cnt <= '0;
            endcase
         end
      end
   end
`else
   assign rep_up = 1'b0;
   assign rep_dn = 1'b0;
`endif

endmodule

// File: tb/tb_synth_param_bank.sv
// Testbench for synth_param_bank: directed vector table, hold/reset sequences,
// and randomized traffic checked against a behavioural model.
module tb_synth_param_bank;

`ifdef PARAM_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   localparam int NP = 6;
   localparam int RD = 10;
   localparam int RR = 4;
   localparam int DEF = 8'h80;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  sel;
   logic        inc, dec, load;
   logic [7:0]  load_value;
   logic [47:0] params_out;
   logic [7:0]  sel_value;
   logic        changed, sat;

   int n_vec = 0;
   int n_err = 0;

   synth_param_bank #(
      .NUM_PARAMS(NP),
      .WIDTH(8),
      .STEP(8),
      .DEFAULTS({6{8'h80}}),
      .REPEAT_DELAY(RD),
      .REPEAT_RATE(RR)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sel(sel),
      .inc(inc),
      .dec(dec),
      .load(load),
      .load_value(load_value),
      .params_out(params_out),
      .sel_value(sel_value),
      .changed(changed),
      .sat(sat)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int m_val [NP];
   bit m_incp, m_decp, m_hold, m_hold_up, m_chg, m_sat;
   int m_t, m_hsel, m_sv;

   task automatic model_clk(input bit r, input int s, input bit i, input bit d,
                            input bit l, input int v);
      bit valid, up, dn;
      int n;
      if (!r) begin
         for (int k = 0; k < NP; k++) m_val[k] = DEF;
         m_sv = (s < NP) ? DEF : 0;
         m_incp = 1; m_decp = 1; m_hold = 0; m_chg = 0; m_sat = 0;
         return;
      end
      valid = (s < NP);
      m_sv  = valid ? m_val[s] : 0;
      m_chg = 0; m_sat = 0; up = 0; dn = 0;
      if (m_hold) begin
         if (!valid || (i && d) || l || s != m_hsel || (m_hold_up ? !i : !d))
            m_hold = 0;
         else begin
            m_t++;
            if (m_t == RD || (m_t > RD && (m_t - RD) % RR == 0)) begin
               up = m_hold_up; dn = !m_hold_up;
            end
         end
      end
      if (valid && !l && !(i && d)) begin
         if (i && !m_incp) begin
            up = 1; m_hold = AR; m_hold_up = 1; m_t = 0; m_hsel = s;
         end else if (d && !m_decp) begin
            dn = 1; m_hold = AR; m_hold_up = 0; m_t = 0; m_hsel = s;
         end
      end
      if (valid && l) begin
         m_chg = (v != m_val[s]);
         m_val[s] = v;
      end else if (up) begin
         n = m_val[s] + 8;
         if (n > 255) begin n = 255; m_sat = 1; end
         m_chg = (n != m_val[s]);
         m_val[s] = n;
      end else if (dn) begin
         if (m_val[s] < 8) begin n = 0; m_sat = 1; end
         else n = m_val[s] - 8;
         m_chg = (n != m_val[s]);
         m_val[s] = n;
      end
      m_incp = i; m_decp = d;
   endtask

   function automatic logic [47:0] model_packed();
      logic [47:0] pk;
      for (int k = 0; k < NP; k++) pk[k*8 +: 8] = 8'(m_val[k]);
      return pk;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic apply(input bit r, input logic [2:0] s, input bit i, input bit d,
                        input bit l, input logic [7:0] v);
      reset = r; sel = s; inc = i; dec = d; load = l; load_value = v;
      @(posedge clk);
      model_clk(r, int'(s), i, d, l, int'(v));
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".params"}, 64'(params_out), 64'(model_packed()));
      chk({tag, ".sel_value"}, 64'(sel_value), 64'(m_sv));
      chk({tag, ".changed"}, 64'(changed), 64'(m_chg));
      chk({tag, ".sat"}, 64'(sat), 64'(m_sat));
   endtask

   typedef struct {
      bit         rst;
      logic [2:0] sel;
      bit         inc, dec, load;
      logic [7:0] lv;
      int         chk_idx;
      logic [7:0] ev, esv;
      bit         echg, esat;
   } vec_t;

   vec_t tbl [24];

   initial begin
      bit r_inc, r_dec, r_load, r_rst;
      logic [2:0] r_sel;
      logic [7:0] r_lv;

      reset = 1'b0; sel = '0; inc = 1'b0; dec = 1'b0; load = 1'b0; load_value = '0;

      //        rst sel   inc dec ld  lv     idx ev     esv    chg sat
      tbl[0]  = '{0, 3'd0, 0, 0, 0, 8'h00, 0, 8'h80, 8'h80, 0, 0};
      tbl[1]  = '{1, 3'd1, 0, 0, 0, 8'h00, 1, 8'h80, 8'h80, 0, 0};
      tbl[2]  = '{1, 3'd1, 1, 0, 0, 8'h00, 1, 8'h88, 8'h80, 1, 0};
      tbl[3]  = '{1, 3'd1, 0, 0, 0, 8'h00, 1, 8'h88, 8'h88, 0, 0};
      tbl[4]  = '{1, 3'd1, 0, 0, 0, 8'h00, 0, 8'h80, 8'h88, 0, 0};
      tbl[5]  = '{1, 3'd2, 0, 0, 1, 8'hFC, 2, 8'hFC, 8'h80, 1, 0};
      tbl[6]  = '{1, 3'd2, 0, 0, 0, 8'h00, 2, 8'hFC, 8'hFC, 0, 0};
      tbl[7]  = '{1, 3'd2, 1, 0, 0, 8'h00, 2, 8'hFF, 8'hFC, 1, 1};
      tbl[8]  = '{1, 3'd2, 0, 0, 0, 8'h00, 2, 8'hFF, 8'hFF, 0, 0};
      tbl[9]  = '{1, 3'd2, 1, 0, 0, 8'h00, 2, 8'hFF, 8'hFF, 0, 1};
      tbl[10] = '{1, 3'd2, 0, 0, 0, 8'h00, 2, 8'hFF, 8'hFF, 0, 0};
      tbl[11] = '{1, 3'd3, 0, 0, 1, 8'h05, 3, 8'h05, 8'h80, 1, 0};
      tbl[12] = '{1, 3'd3, 0, 0, 0, 8'h00, 3, 8'h05, 8'h05, 0, 0};
      tbl[13] = '{1, 3'd3, 0, 1, 0, 8'h00, 3, 8'h00, 8'h05, 1, 1};
      tbl[14] = '{1, 3'd3, 0, 0, 0, 8'h00, 3, 8'h00, 8'h00, 0, 0};
      tbl[15] = '{1, 3'd0, 1, 0, 1, 8'h3C, 0, 8'h3C, 8'h80, 1, 0};
      tbl[16] = '{1, 3'd0, 0, 0, 0, 8'h00, 0, 8'h3C, 8'h3C, 0, 0};
      tbl[17] = '{1, 3'd0, 1, 1, 0, 8'h00, 0, 8'h3C, 8'h3C, 0, 0};
      tbl[18] = '{1, 3'd0, 0, 0, 0, 8'h00, 0, 8'h3C, 8'h3C, 0, 0};
      tbl[19] = '{1, 3'd7, 1, 0, 0, 8'h00, 5, 8'h80, 8'h00, 0, 0};
      tbl[20] = '{1, 3'd5, 0, 0, 0, 8'h00, 5, 8'h80, 8'h80, 0, 0};
      tbl[21] = '{1, 3'd4, 0, 0, 1, 8'h80, 4, 8'h80, 8'h80, 0, 0};
      tbl[22] = '{1, 3'd4, 0, 1, 0, 8'h00, 4, 8'h78, 8'h80, 1, 0};
      tbl[23] = '{1, 3'd4, 0, 0, 0, 8'h00, 4, 8'h78, 8'h78, 0, 0};

      @(negedge clk);
      for (int v = 0; v < 24; v++) begin
         apply(tbl[v].rst, tbl[v].sel, tbl[v].inc, tbl[v].dec, tbl[v].load, tbl[v].lv);
         chk($sformatf("tbl%0d.value", v), 64'(params_out[tbl[v].chk_idx*8 +: 8]), 64'(tbl[v].ev));
         chk($sformatf("tbl%0d.sel_value", v), 64'(sel_value), 64'(tbl[v].esv));
         chk($sformatf("tbl%0d.changed", v), 64'(changed), 64'(tbl[v].echg));
         chk($sformatf("tbl%0d.sat", v), 64'(sat), 64'(tbl[v].esat));
      end

      // Hold inc for 30 cycles from 0x00: repeat steps only when auto-repeat is built.
      apply(1, 3'd0, 0, 0, 1, 8'h00);
      apply(1, 3'd0, 0, 0, 0, 8'h00);
      for (int k = 0; k < 30; k++) begin
         apply(1, 3'd0, 1, 0, 0, 8'h00);
         chk($sformatf("hold%0d.changed", k), 64'(changed),
             64'((k == 0) || (AR && k >= RD && (k - RD) % RR == 0)));
      end
      chk("hold.final", 64'(params_out[7:0]), AR ? 64'h30 : 64'h08);
      apply(1, 3'd0, 0, 0, 0, 8'h00);

      // Key held through reset release: no step until released and re-pressed.
      apply(0, 3'd1, 1, 0, 0, 8'h00);
      apply(0, 3'd1, 1, 0, 0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         apply(1, 3'd1, 1, 0, 0, 8'h00);
         chk($sformatf("rsthold%0d.value", k), 64'(params_out[15:8]), 64'h80);
         chk($sformatf("rsthold%0d.changed", k), 64'(changed), 64'h0);
      end
      apply(1, 3'd1, 0, 0, 0, 8'h00);
      apply(1, 3'd1, 1, 0, 0, 8'h00);
      chk("repress.value", 64'(params_out[15:8]), 64'h88);
      chk("repress.changed", 64'(changed), 64'h1);
      for (int k = 0; k < 12; k++) apply(1, 3'd1, 1, 0, 0, 8'h00);
      // Reset in the middle of a hold: defaults, no step in that cycle.
      apply(0, 3'd1, 1, 0, 0, 8'h00);
      chk("midrst.value", 64'(params_out[15:8]), 64'h80);
      chk("midrst.changed", 64'(changed), 64'h0);
      apply(1, 3'd1, 1, 0, 0, 8'h00);
      chk("midrst.after", 64'(params_out[15:8]), 64'h80);
      apply(1, 3'd1, 0, 0, 0, 8'h00);
      chk_model("sync");

      // Randomized traffic with long holds so repeats and aborts occur.
      r_inc = 0; r_dec = 0; r_sel = 3'd0;
      for (int k = 0; k < 600; k++) begin
         if ($urandom % 9 == 0)  r_inc = ~r_inc;
         if ($urandom % 11 == 0) r_dec = ~r_dec;
         if ($urandom % 20 == 0) r_sel = 3'($urandom % 8);
         r_load = ($urandom % 25 == 0);
         r_rst  = ($urandom % 120 != 0);
         r_lv   = 8'($urandom);
         apply(r_rst, r_sel, r_inc, r_dec, r_load, r_lv);
         chk_model($sformatf("rnd%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
